// File: rtl/pixel_readout.sv
// pixel_readout: captures pixel rows into a FIFO and serializes them as a byte stream with frame-end marking.
module pixel_readout #(
  parameter int DEPTH = 4,
  parameter int ROWS  = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   pixData1,
  input  logic [7:0]                   pixData2,
  input  logic [7:0]                   pixData3,
  input  logic [7:0]                   pixData4,
  input  logic                         pixValid,
  input  logic                         frameStart,
  output logic [7:0]                   out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic                         overflow,
  output logic [$clog2(DEPTH+1)-1:0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = ROWS > 1 ? $clog2(ROWS) : 1;
  logic [32:0]   mem [DEPTH];
  logic [AW:0]   wptr, rptr;
  logic [1:0]    idx;
  logic [CW-1:0] row, row_base, row_next;
  logic [32:0]   head;
  logic          full, xfer, pop, push, drop, last;
  assign head      = mem[rptr[AW-1:0]];
  assign out_valid = wptr != rptr;
  assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign xfer      = out_valid & out_ready;
  assign pop       = xfer & (idx == 2'd3);
  assign push      = pixValid & (~full | pop);
  assign drop      = pixValid & ~push;
  assign level     = wptr - rptr;
  assign out_data  = out_valid ? head[{idx, 3'b000} +: 8] : 8'h00;
  assign out_last  = out_valid & (idx == 2'd3) & head[32];
  // a coincident frameStart makes the incoming row count as row 0
  always_comb begin
    row_base = frameStart ? '0 : row;
    last     = row_base == CW'(ROWS - 1);
    row_next = last ? '0 : row_base + 1'b1;
  end
  always_ff @(posedge clk)
    if (push) mem[wptr[AW-1:0]] <= {last, pixData4, pixData3, pixData2, pixData1};
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wptr     <= '0;
      rptr     <= '0;
      idx      <= '0;
      row      <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      if (xfer) idx <= idx + 2'd1;
      row      <= pixValid ? row_next : row_base;
      overflow <= (overflow & ~frameStart) | drop;
    end
endmodule

// File: tb/tb_pixel_readout.sv
// tb_pixel_readout: directed checks of capture, serialization, backpressure, overflow and async reset.
module tb_pixel_readout;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pixData1, pixData2, pixData3, pixData4;
  logic       pixValid, frameStart, out_ready;
  logic [7:0] out_data;
  logic       out_valid, out_last, overflow;
  logic [2:0] level;
  int         total = 0;
  int         passed = 0;
  pixel_readout #(.DEPTH(4), .ROWS(2)) dut (
    .clk(clk), .reset(reset),
    .pixData1(pixData1), .pixData2(pixData2), .pixData3(pixData3), .pixData4(pixData4),
    .pixValid(pixValid), .frameStart(frameStart),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .overflow(overflow), .level(level)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive_row(input logic [31:0] r);
    {pixData4, pixData3, pixData2, pixData1} = r;
    pixValid = 1'b1;
  endtask
  task automatic idle_bus();
    {pixData4, pixData3, pixData2, pixData1} = 'x;
    pixValid = 1'b0;
  endtask
  task automatic drain_row(input string tag, input logic [31:0] r, input logic lst);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_valid"}, out_valid, 1'b1);
      chk({tag, "_data"}, out_data, r[8*i +: 8]);
      chk({tag, "_last"}, out_last, (i == 3) ? lst : 1'b0);
      tick();
    end
  endtask
  initial begin
    reset = 1'b0;
    frameStart = 1'b0;
    out_ready = 1'b0;
    idle_bus();
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_level", level, 3'd0);
    chk("rst_data", out_data, 8'h00);
    chk("rst_last", out_last, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    // single row, free-running consumer
    out_ready = 1'b1;
    drive_row(32'h44332211);
    tick();
    idle_bus();
    chk("t1_level", level, 3'd1);
    drain_row("t1", 32'h44332211, 1'b0);
    chk("t1_valid_end", out_valid, 1'b0);
    chk("t1_level_end", level, 3'd0);
    // frame marker across three rows
    frameStart = 1'b1;
    out_ready = 1'b0;
    tick();
    frameStart = 1'b0;
    drive_row(32'hA3A2A1A0);
    tick();
    drive_row(32'hB3B2B1B0);
    tick();
    drive_row(32'hC3C2C1C0);
    tick();
    idle_bus();
    chk("t2_level", level, 3'd3);
    out_ready = 1'b1;
    drain_row("t2a", 32'hA3A2A1A0, 1'b0);
    drain_row("t2b", 32'hB3B2B1B0, 1'b1);
    drain_row("t2c", 32'hC3C2C1C0, 1'b0);
    chk("t2_level_end", level, 3'd0);
    // backpressure, with frameStart coincident with the row
    out_ready = 1'b0;
    frameStart = 1'b1;
    drive_row(32'hD3D2D1D0);
    tick();
    frameStart = 1'b0;
    idle_bus();
    for (int i = 0; i < 10; i++) begin
      chk("t3_hold_data", out_data, 8'hD0);
      chk("t3_hold_valid", out_valid, 1'b1);
      tick();
    end
    out_ready = 1'b1;
    drain_row("t3", 32'hD3D2D1D0, 1'b0);
    chk("t3_level_end", level, 3'd0);
    // overflow: five rows into a depth-4 FIFO
    frameStart = 1'b1;
    out_ready = 1'b0;
    tick();
    frameStart = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_row({4{8'hE0 + 8'(i)}});
      tick();
    end
    idle_bus();
    chk("t4_level", level, 3'd4);
    chk("t4_ovf", overflow, 1'b1);
    frameStart = 1'b1;
    tick();
    frameStart = 1'b0;
    chk("t4_ovf_clr", overflow, 1'b0);
    chk("t4_level_keep", level, 3'd4);
    // full: pop on final byte with simultaneous push
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t5_pre_data", out_data, 8'hE0);
      tick();
    end
    chk("t5_pre_last", out_last, 1'b0);
    chk("t5_pre_data3", out_data, 8'hE0);
    drive_row(32'hF3F2F1F0);
    tick();
    idle_bus();
    chk("t5_level", level, 3'd4);
    chk("t5_ovf", overflow, 1'b0);
    drain_row("t5e1", 32'hE1E1E1E1, 1'b1);
    drain_row("t5e2", 32'hE2E2E2E2, 1'b0);
    drain_row("t5e3", 32'hE3E3E3E3, 1'b1);
    drain_row("t5f", 32'hF3F2F1F0, 1'b0);
    chk("t5_level_end", level, 3'd0);
    chk("t5_valid_end", out_valid, 1'b0);
    // asynchronous reset mid-row
    drive_row(32'h9C9B9A99);
    tick();
    idle_bus();
    tick();
    tick();
    chk("t6_idx2_data", out_data, 8'h9B);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_valid", out_valid, 1'b0);
    chk("t6_level", level, 3'd0);
    chk("t6_last", out_last, 1'b0);
    chk("t6_data", out_data, 8'h00);
    #2;
    reset = 1'b1;
    tick();
    drive_row(32'h44434241);
    tick();
    idle_bus();
    drain_row("t6new", 32'h44434241, 1'b0);
    chk("t6_level_end", level, 3'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pixel_readout.md
# pixel_readout

Downstream stage of `pixelTop`. It captures the four 8-bit pixel buses `pixData1`..`pixData4` whenever the pixel controller strobes a valid readout row, and buffers each row as one 32-bit entry in a small FIFO. It serializes the rows into a byte stream with a valid/ready handshake and a frame-end marker. This decouples the pixel array's fixed readout timing from a slower or stalling consumer.

## Interface
- `DEPTH`, 4, FIFO depth in rows; power of two, ≥2
- `ROWS`, 2, readout rows per frame; ≥1
- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  one clock; reset is asynchronous and active-low
- `pixData1`..`pixData4`  in  8 each  pixel buses from `pixelTop`; sampled only when `pixValid`=1; may be Z/X otherwise
- `pixValid`  in  1  one-cycle strobe: buses carry one valid row this cycle
- `frameStart`  in  1  one-cycle sync pulse: new frame begins
- `out_data`  out  8  current output byte
- `out_valid`  out  1  `out_data` is valid
- `out_ready`  in  1  consumer accepts byte
- `out_last`  out  1  qualifies the final byte of a frame
- `overflow`  out  1  sticky: at least one row dropped since last `frameStart`/reset
- `level`  out  clog2(DEPTH+1)  rows currently stored

## Operation
- Reset asserted (`reset`=0): FIFO emptied, pointers/byte index/row counter = 0. `out_valid`=0, `out_last`=0, `overflow`=0, `level`=0. `out_data`=0. Takes effect immediately, mid-stream data discarded.
- Entry format: {last, pixData4, pixData3, pixData2, pixData1}, 33 bits.
- Write side:
  - On `pixValid`=1 and (not full, or a pop in same cycle), store entry.
  - `last` = (write row counter == ROWS-1).
  - Row counter increments per accepted row, wraps to 0 after ROWS-1.
  - `pixValid` while full with no same-cycle pop: row dropped, `overflow`←1, row counter still increments (frame alignment kept).
- `frameStart`: row counter←0, `overflow`←0. If coincident with `pixValid`, the row is written as row 0. FIFO contents and read side untouched.
- Read side:
  - `out_valid` = FIFO non-empty.
  - `out_data` = head entry byte[idx], with idx 0..3 selecting pixData1..pixData4.
  - Transfer = `out_valid` & `out_ready`. Each transfer increments idx; at idx==3 the head is popped and idx←0.
  - `out_last` = `out_valid` & idx==3 & head.last.
- `level` = write pointer − read pointer (extra wrap bit), range 0..DEPTH. Simultaneous push and pop leaves `level` unchanged.
- `out_ready` while `out_valid`=0: ignored.

## Timing
- Latency: `pixValid` sampled at edge k → `out_valid`=1 with byte pixData1 after edge k (empty FIFO, no bypass).
- While `out_valid`=1 and `out_ready`=0: `out_data`/`out_last` held stable. `out_valid` never drops without a transfer.
- Full throughput: one byte per clock with `out_ready` held high. The consumer drains one row per 4 cycles, so sustained `pixValid` faster than 1 per 4 cycles fills the FIFO.
- Pop on the final byte and push in the same edge when full: both happen, `level` stays DEPTH, `overflow` unchanged.
- `overflow` set on the edge of the dropped `pixValid`, visible the following cycle.
- Outputs are combinational from registers only (no input→output combinational path except none; `out_ready` affects state only).

## Test plan
- Reset then single row: `pixValid` with buses 11,22,33,44 and `out_ready`=1 → bytes 0x11,0x22,0x33,0x44 on consecutive cycles. `out_last`=0 (row 0 of ROWS=2). `level` 1→0 after 4th byte.
- Frame marker: `frameStart`, then two rows A0..A3, B0..B3 → 8 bytes in order, `out_last`=1 only on B3. Third row's byte 3 has `out_last`=0.
- Backpressure: `out_ready`=0 for 10 cycles after first row → `out_data`=pixData1 value held, `out_valid`=1. Release → remaining bytes follow without loss.
- Overflow: `out_ready`=0, 5 strobes with DEPTH=4 → `level`=4, `overflow`=1, the 5th row never emitted. `frameStart` → `overflow`=0.
- Full push+pop: FIFO full, `out_ready`=1 on idx 3 coincident with `pixValid` → row accepted, `level` stays 4, `overflow` stays 0.
- Async reset mid-stream: drop `reset` at idx=2 between clock edges → `out_valid`, `level`, `out_last` go 0 immediately. After release, a new row starts at pixData1.
